param_shift_register_ce_sreset: RTL and testbench
=================================================

Name: param_shift_register_ce_sreset

Overview:
- Parametrised universal shift register: WIDTH-bit storage with clock enable, synchronous reset, parallel load, bidirectional serial shift and a shift-count/done tracker.
- Generalises the single-bit CE/sync-reset D flip-flop to a word-wide register with operating modes.
- Serves as the building block for serialisers, deserialisers and bit-sliced datapaths in lab designs.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, '0 (WIDTH bits), value loaded into Q on reset.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- ce  input  1  clock enable; when low, all state holds.
- mode  input  2  operation select, encoded as shift_mode_t (see Behaviour).
- D  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering at the MSB during shift-right.
- sin_l  input  1  serial input entering at the LSB during shift-left.
- rotate  input  1  present only when USR_ROTATE_EN is defined.
- Q  output  WIDTH  register contents.
- sout_r  output  1  equals Q[0], the bit shifted out on a right shift.
- sout_l  output  1  equals Q[WIDTH-1], the bit shifted out on a left shift.
- shift_cnt  output  $clog2(WIDTH+1)  number of shifts since the last load or reset.
- done  output  1  one-cycle pulse when shift_cnt reaches WIDTH.

Behaviour:
- Reset is decided as: reset synchronous, active-high; clock Clk.
- On reset: Q=RESET_VAL, shift_cnt=0, done=0. Reset overrides ce and mode.
- When ce=0 and reset=0: Q and shift_cnt hold, and done=0. A pulse lasts exactly one edge.
- Mode encoding with ce=1:
  - 2'b00 HOLD: Q holds.
  - 2'b01 SHR: Q <= {sin_r, Q[WIDTH-1:1]}.
  - 2'b10 SHL: Q <= {Q[WIDTH-2:0], sin_l}.
  - 2'b11 LOAD: Q <= D.
- Latency: Q updates on the same edge as the command; no pipeline stage.
- shift_cnt:
  - Cleared by LOAD.
  - Incremented by SHR/SHL while less than WIDTH; saturates at WIDTH.
  - Held by HOLD.
- done: registered; set to 1 on the edge where shift_cnt goes from WIDTH-1 to WIDTH, otherwise 0.
  - No re-assertion while shift_cnt is saturated.
  - A LOAD re-arms the tracker.
- Mixed SHR/SHL sequences all count toward shift_cnt; direction is not tracked.
- sout_r and sout_l are combinational taps of Q; they present the bit about to leave on the next shift.
- Reset mid-serialisation aborts: the count is lost and done is not asserted.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined:
  - rotate port exists.
  - With rotate=1, SHR inserts Q[0] at the MSB and SHL inserts Q[WIDTH-1] at the LSB; sin_r/sin_l are ignored.
  - Rotates count toward shift_cnt and done like shifts.
  - rotate has no effect in HOLD or LOAD.
- Undefined: no rotate port; shifts always use sin_r/sin_l.

Decomposition:
- Package usr_pkg:
  - typedef enum logic [1:0] shift_mode_t {MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD}.
  - Helper function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- One sub-module, usr_shift_counter: saturating counter plus done pulse generator.
  - Inputs: Clk, reset, ce, clr, inc.
  - Parameter: MAX=WIDTH.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5; drive reset=1 with ce=0 and mode=LOAD, D=8'hFF. Expect Q=8'hA5, shift_cnt=0, done=0 after the edge.
- CE gating: LOAD 8'h3C, then ce=0 with mode=SHL for 5 cycles. Expect Q stays 8'h3C and shift_cnt stays 0.
- Serialise right: LOAD 8'b1011_0010, then 8×SHR with sin_r=0.
  - sout_r sequence is 0,1,0,0,1,1,0,1.
  - done pulses exactly on the 8th edge, with shift_cnt=8.
  - A 9th SHR gives shift_cnt=8 and done=0.
- Deserialise left: LOAD 0, then 8×SHL with sin_l sequence 1,1,0,0,1,0,1,0. Expect Q=8'hCA and done pulses once.
- Reset mid-op: LOAD 8'hF0, 4×SHR, then reset. Expect Q=RESET_VAL, shift_cnt=0, and no done pulse on any subsequent HOLD cycles.
- Rotate (USR_ROTATE_EN): LOAD 8'h81, then SHL with rotate=1. Expect Q=8'h03; after 8 rotates Q=8'h81 and done pulses.

Source files
------------

// File: rtl/param_shift_register_ce_sreset_pkg.sv
// Shared types and helpers for the universal shift register slice.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;

  // Width of a counter that must be able to hold the value `width` itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/param_shift_register_ce_sreset_counter.sv
// Saturating shift counter with a one-edge done pulse on the MAX-1 -> MAX step.
module usr_shift_counter
  import usr_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        clr,
  input  logic                        inc,
  output logic [cnt_width(MAX)-1:0]   shift_cnt,
  output logic                        done
);

  localparam int            CW     = cnt_width(MAX);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX);
  localparam logic [CW-1:0] MAX_M1 = CW'(MAX - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!ce) begin
      r_done <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (inc && (r_cnt != MAX_C)) begin
      r_cnt  <= r_cnt + ONE;
      r_done <= (r_cnt == MAX_M1);
    end else begin
      r_done <= 1'b0;
    end
  end

  assign shift_cnt = r_cnt;
  assign done      = r_done;

endmodule

// File: rtl/param_shift_register_ce_sreset.sv
// Universal WIDTH-bit shift register with CE, sync reset, load and shift tracking.
// Optional rotate input enabled by defining USR_ROTATE_EN.
module param_shift_register_ce_sreset
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          ce,
  input  shift_mode_t                   mode,
  input  logic [WIDTH-1:0]              D,
  input  logic                          sin_r,
  input  logic                          sin_l,
`ifdef USR_ROTATE_EN
  input  logic                          rotate,
`endif
  output logic [WIDTH-1:0]              Q,
  output logic                          sout_r,
  output logic                          sout_l,
  output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
  output logic                          done
);

  logic [WIDTH-1:0] r_q;
  logic             w_in_r;
  logic             w_in_l;
  logic             w_is_shift;
  logic             w_is_load;

`ifdef USR_ROTATE_EN
  assign w_in_r = rotate ? r_q[0]       : sin_r;
  assign w_in_l = rotate ? r_q[WIDTH-1] : sin_l;
`else
  assign w_in_r = sin_r;
  assign w_in_l = sin_l;
`endif

  assign w_is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);
  assign w_is_load  = (mode == MODE_LOAD);

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (ce) begin
      case (mode)
        MODE_SHR:  r_q <= {w_in_r, r_q[WIDTH-1:1]};
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], w_in_l};
        MODE_LOAD: r_q <= D;
        default:   r_q <= r_q;
      endcase
    end
  end

  usr_shift_counter #(
    .MAX (WIDTH)
  ) u_counter (
    .Clk       (Clk),
    .reset     (reset),
    .ce        (ce),
    .clr       (w_is_load),
    .inc       (w_is_shift),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  assign Q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_param_shift_register_ce_sreset.sv
// Self-checking bench: directed scenarios plus random traffic against a word-level model.
module tb_param_shift_register_ce_sreset;
  import usr_pkg::*;

  localparam int         W   = 8;
  localparam int         CW  = cnt_width(W);
  localparam logic [7:0] RV  = 8'hA5;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          ce = 1'b0;
  shift_mode_t   mode = MODE_HOLD;
  logic [W-1:0]  D = '0;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic          rotate = 1'b0;
  logic [W-1:0]  Q;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] shift_cnt;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain integers and the behavioural rules.
  int m_q   = 0;
  int m_cnt = 0;
  int m_done = 0;
  int done_seen = 0;

  always #5 Clk = ~Clk;

  param_shift_register_ce_sreset #(
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .ce        (ce),
    .mode      (mode),
    .D         (D),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
`ifdef USR_ROTATE_EN
    .rotate    (rotate),
`endif
    .Q         (Q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit rst, input bit en, input int md,
                                     input int d, input bit sr, input bit sl, input bit rot);
    int prev;
    bit ins;
    if (rst) begin
      m_q = RV; m_cnt = 0; m_done = 0;
    end else if (!en) begin
      m_done = 0;
    end else if (md == 3) begin
      m_q = d; m_cnt = 0; m_done = 0;
    end else if (md == 0) begin
      m_done = 0;
    end else begin
      prev = m_cnt;
      if (md == 1) begin
        ins = sr;
`ifdef USR_ROTATE_EN
        if (rot) ins = bit'(m_q % 2);
`endif
        m_q = (m_q / 2) + (ins ? 128 : 0);
      end else begin
        ins = sl;
`ifdef USR_ROTATE_EN
        if (rot) ins = bit'(m_q / 128);
`endif
        m_q = ((m_q * 2) % 256) + (ins ? 1 : 0);
      end
      if (m_cnt < W) m_cnt = m_cnt + 1;
      m_done = (prev == W - 1) ? 1 : 0;
    end
  endfunction

  task automatic step(input bit rst, input bit en, input int md, input int d,
                      input bit sr, input bit sl);
    reset = rst;
    ce    = en;
    mode  = shift_mode_t'(md[1:0]);
    D     = d[7:0];
    sin_r = sr;
    sin_l = sl;
    @(posedge Clk);
    model_edge(rst, en, md, d, sr, sl, rotate);
    #1;
    if (done === 1'b1) done_seen++;
    check("Q",         64'(Q),         64'(m_q));
    check("shift_cnt", 64'(shift_cnt), 64'(m_cnt));
    check("done",      64'(done),      64'(m_done));
    check("sout_r",    64'(sout_r),    64'(m_q % 2));
    check("sout_l",    64'(sout_l),    64'(m_q / 128));
  endtask

  initial begin
    logic [7:0] sout_seq;
    logic [7:0] sin_seq;
    int md;

    // Reset overrides ce=0 and a pending LOAD.
    step(1, 0, 3, 8'hFF, 0, 0);
    check("rst_Q", 64'(Q), 64'(8'hA5));
    check("rst_cnt", 64'(shift_cnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // CE gating.
    step(0, 1, 3, 8'h3C, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 2, 8'h00, 0, 1);
    check("ce_Q", 64'(Q), 64'(8'h3C));
    check("ce_cnt", 64'(shift_cnt), 64'd0);

    // Serialise right: sout_r before each shift is 0,1,0,0,1,1,0,1 (index 0 first).
    sout_seq = 8'b1011_0010;
    step(0, 1, 3, 8'b1011_0010, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      check("ser_sout_r", 64'(sout_r), 64'(sout_seq[i]));
      step(0, 1, 1, 0, 0, 0);
      if (i < 7) check("ser_no_early_done", 64'(done), 64'd0);
    end
    check("ser_done8", 64'(done), 64'd1);
    check("ser_cnt8", 64'(shift_cnt), 64'd8);
    step(0, 1, 1, 0, 0, 0);
    check("ser_cnt9", 64'(shift_cnt), 64'd8);
    check("ser_done9", 64'(done), 64'd0);
    check("ser_done_count", 64'(done_seen), 64'd1);

    // Deserialise left: sin_l 1,1,0,0,1,0,1,0 (index 7 first).
    sin_seq = 8'b1100_1010;
    step(0, 1, 3, 0, 0, 0);
    done_seen = 0;
    for (int i = 7; i >= 0; i--) step(0, 1, 2, 0, 0, sin_seq[i]);
    check("des_Q", 64'(Q), 64'(8'hCA));
    check("des_done_count", 64'(done_seen), 64'd1);

    // Reset mid-operation aborts the count; no pulse afterwards.
    step(0, 1, 3, 8'hF0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 0);
    done_seen = 0;
    step(1, 1, 1, 0, 1, 0);
    check("abort_Q", 64'(Q), 64'(8'hA5));
    check("abort_cnt", 64'(shift_cnt), 64'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    check("abort_no_done", 64'(done_seen), 64'd0);

`ifdef USR_ROTATE_EN
    rotate = 1'b1;
    step(0, 1, 3, 8'h81, 0, 0);
    done_seen = 0;
    step(0, 1, 2, 0, 0, 0);
    check("rot_Q1", 64'(Q), 64'(8'h03));
    for (int i = 1; i < 8; i++) step(0, 1, 2, 0, 0, 0);
    check("rot_Q8", 64'(Q), 64'(8'h81));
    check("rot_done_count", 64'(done_seen), 64'd1);
    rotate = 1'b0;
`endif

    // Random traffic, with LOAD less frequent so counts reach saturation.
    for (int i = 0; i < 600; i++) begin
      md = int'($urandom_range(0, 9));
      md = (md < 4) ? 1 : (md < 8) ? 2 : (md == 8) ? 0 : 3;
`ifdef USR_ROTATE_EN
      rotate = 1'($urandom);
`endif
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), md,
           int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
